// File: rtl/fanout_bcast_buf_pkg.sv
// Shared constants, types and the retire rule for the fanout broadcast buffer.
// The downstream ready-combine imports the same all_done() so both sides agree on retirement.
package fanout_pkg;

    localparam int NUM_SINKS = 9;
    localparam int DATA_W    = 17;

    typedef logic [NUM_SINKS-1:0] sink_mask_t;
    typedef logic [DATA_W-1:0]    data_t;

    function automatic logic all_done(input sink_mask_t en,
                                      input sink_mask_t served,
                                      input sink_mask_t hs);
        return &(~en | served | hs);
    endfunction

endpackage

// File: rtl/fanout_bcast_buf_if.sv
// Upstream ready-valid stream plus the broadcast side toward the sinks.
interface fanout_bcast_buf_if;
    import fanout_pkg::*;

    data_t      in_data;
    logic       in_valid;
    logic       in_ready;
    data_t      out_data;
    sink_mask_t out_valid;
    sink_mask_t sink_ready;

    modport master (
        output in_data, in_valid, sink_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, sink_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/fanout_bcast_buf_served_tracker.sv
// Per-sink delivery bookkeeping for the head entry: valid masking, handshakes and retire.
module fanout_served_tracker
    import fanout_pkg::*;
(
    input  logic       CLK,
    input  logic       ASYNCRESET,
    input  logic       flush,
    input  logic       head_valid,
    input  sink_mask_t sink_en,
    input  sink_mask_t sink_ready,
    output sink_mask_t out_valid,
    output logic       retire
);

    sink_mask_t served_r;
    sink_mask_t served_next_s;
    sink_mask_t hs_s;

    // per-sink valid, handshake and head retire decision
    always_comb begin
        out_valid = {NUM_SINKS{head_valid}} & sink_en & ~served_r;
        hs_s      = out_valid & sink_ready;
        retire    = head_valid & all_done(sink_en, served_r, hs_s);
    end

    // served bits restart for every new head entry
    always_comb begin
        served_next_s = served_r;
        if (flush) begin
            served_next_s = {NUM_SINKS{1'b0}};
        end else if (retire) begin
            served_next_s = {NUM_SINKS{1'b0}};
        end else begin
            served_next_s = served_r | hs_s;
        end
    end

    // served register
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            served_r <= {NUM_SINKS{1'b0}};
        end else begin
            served_r <= served_next_s;
        end
    end

endmodule

// File: rtl/fanout_bcast_buf.sv
// Two-entry broadcast buffer: one upstream stream, each word held until every enabled sink took it.
module fanout_bcast_buf
    import fanout_pkg::*;
(
    input  logic                CLK,
    input  logic                ASYNCRESET,
    input  logic                flush,
    input  sink_mask_t          sink_en,
    fanout_bcast_buf_if.slave   bus,
    output logic [1:0]          occupancy
);

    data_t      mem_r [2];
    logic       head_ptr_r;
    logic       tail_ptr_r;
    logic [1:0] count_r;
    logic       in_ready_r;

    logic       enq_s;
    logic       retire_s;
    logic       head_valid_s;
    logic [1:0] count_next_s;

    assign enq_s        = bus.in_valid & in_ready_r;
    assign head_valid_s = (count_r != 2'd0);
    assign bus.in_ready = in_ready_r;
    assign bus.out_data = mem_r[head_ptr_r];
    assign occupancy    = count_r;

    fanout_served_tracker u_tracker (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .flush      (flush),
        .head_valid (head_valid_s),
        .sink_en    (sink_en),
        .sink_ready (bus.sink_ready),
        .out_valid  (bus.out_valid),
        .retire     (retire_s)
    );

    // next occupancy; flush overrides any simultaneous enqueue or retire
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = 2'd0;
        end else begin
            case ({enq_s, retire_s})
                2'b10:   count_next_s = count_r + 2'd1;
                2'b01:   count_next_s = count_r - 2'd1;
                default: count_next_s = count_r;
            endcase
        end
    end

    // pointers, count and the registered upstream ready
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            head_ptr_r <= 1'b0;
            tail_ptr_r <= 1'b0;
            count_r    <= 2'd0;
            in_ready_r <= 1'b0;
        end else if (flush) begin
            head_ptr_r <= 1'b0;
            tail_ptr_r <= 1'b0;
            count_r    <= 2'd0;
            in_ready_r <= 1'b1;
        end else begin
            if (enq_s) begin
                tail_ptr_r <= ~tail_ptr_r;
            end
            if (retire_s) begin
                head_ptr_r <= ~head_ptr_r;
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s < 2'd2);
        end
    end

    // entry storage; cleared on reset so out_data reads zero while empty after reset
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            mem_r[0] <= {DATA_W{1'b0}};
            mem_r[1] <= {DATA_W{1'b0}};
        end else if (enq_s && !flush) begin
            mem_r[tail_ptr_r] <= bus.in_data;
        end else begin
            mem_r <= mem_r;
        end
    end

endmodule

// File: doc/fanout_bcast_buf.md
Name: fanout_bcast_buf

Overview:
- Two-entry broadcast buffer sitting directly upstream of the fanout ready-combine logic on a switchbox/PE output.
- Accepts one ready-valid stream and presents each word to up to NUM_SINKS enabled sinks.
- Tracks per-sink delivery, so sinks may accept the same word on different cycles. The word retires only when every enabled sink has taken it.
- Removes the all-sinks-ready-same-cycle requirement and the combinational sink_ready-to-in_ready path.

Parameters:
- NUM_SINKS, 9, number of fanout destinations.
- DATA_W, 17, payload width (16-bit data plus 1 control/token bit).

Ports:
- CLK  input  1  clock; all state on rising edge.
- ASYNCRESET  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of all entries and served bits.
- sink_en  input  NUM_SINKS  per-sink enable (config); a disabled sink never blocks retirement.
- in_data  input  DATA_W  upstream payload.
- in_valid  input  1  upstream valid.
- in_ready  output  1  upstream ready; registered.
- out_data  output  DATA_W  head-entry payload, common to all sinks.
- out_valid  output  NUM_SINKS  per-sink valid.
- sink_ready  input  NUM_SINKS  per-sink ready.
- occupancy  output  2  entries held (0..2); debug/perf.

Behaviour:
- Reset (ASYNCRESET high, any time): count=0, served=0, in_ready=0 while reset is asserted, in_ready=1 on the first edge after release, out_valid=0, out_data=0, occupancy=0. Entry storage is don't-care.
- Storage: 2-entry circular buffer. head_ptr and tail_ptr are 1-bit each, plus count (0..2), plus served[NUM_SINKS] for the head entry only.
- Enqueue: fires when in_valid & in_ready. Writes tail and advances tail_ptr.
- in_ready: registered. Equals (next_count < 2). Never combinationally dependent on sink_ready.
- Output: out_data = head entry.
  - out_valid[i] = (count != 0) & sink_en[i] & ~served[i].
- Per-sink handshake: hs[i] = out_valid[i] & sink_ready[i].
- Retire: done[i] = ~sink_en[i] | served[i] | hs[i]. Retire the head when count != 0 and AND(done) = 1.
  - On retire: head_ptr advances and served clears to 0.
  - Otherwise: served |= hs.
- Latency: a word enqueued at edge N is visible on out_valid after edge N; minimum 1 cycle. Throughput: 1 word/cycle when all enabled sinks are ready.
- Simultaneous enqueue and retire: count unchanged. Legal at count=1. At count=2, in_ready is 0, so no enqueue occurs.
- All sinks disabled: any held word retires on the first cycle it is head (drop behaviour). No deadlock.
- Empty: out_valid=0 and sink_ready is ignored; served stays 0.
- sink_en changes: sink_en must be static while count != 0. If it changes anyway, the new value is used the same cycle. Clearing a bit never blocks; setting a bit may cause a duplicate-free late delivery only to that sink.
- Flush: count=0, served=0, pointers=0. in_ready=1 from the next cycle. Flush wins over a simultaneous enqueue (the word is dropped) and over a simultaneous retire.
- Reset mid-operation: all held words are lost; no partial served state survives.
- Pointer wrap: the 1-bit pointers wrap naturally. count is the sole full/empty indicator.

Decomposition:
- Package fanout_pkg: DATA_W and NUM_SINKS defaults, and typedef sink_mask_t (logic [NUM_SINKS-1:0]).
- Package also holds a function all_done(en, served, hs). It is shared with the downstream ready-combine so both agree on the retire rule.
- One natural sub-module: fanout_served_tracker. It holds the served register and computes hs, done and retire from sink_en, sink_ready and head valid.
- Buffer storage, pointers and count stay in the top.

Test Plan:
- Reset release, sink_en=9'h1FF, push 0x0AAAA → out_valid=9'h1FF one cycle later, out_data=0x0AAAA. All sinks ready → retire that cycle; occupancy returns to 0.
- Staggered acceptance, sink_en=9'h007, push 0x00011.
  - sink_ready=001 then 010 then 100 on consecutive cycles → out_valid goes 111, 110, 100, then 000.
  - Word retires on the third handshake cycle; sink 0 sees no duplicate.
- Backpressure, sink_ready=0, push 3 words → in_ready=0 after the 2nd accept and the 3rd is held upstream.
  - Release all ready → words delivered in order 1, 2, 3, then occupancy=0.
- sink_en=0, push 0x00055 → word dropped; occupancy 1 for one cycle, then 0; out_valid stays 0.
- Streaming, all 9 enabled and always ready, in_valid held for 20 cycles → 20 words delivered in order, in_ready constantly 1.
- Mid-operation events: with 2 words held and sink 4 served, assert flush → occupancy=0, out_valid=0, in_ready=1 next cycle.
  - Repeat with ASYNCRESET pulsed between clock edges → the same state appears immediately.
